// File: rtl/headlight_lamp_driver.sv
// Headlamp driver: soft-ramped PWM gate drive with latched lamp fault.
// Sits between the headlight controller and the lamp FET gate driver.
module headlight_lamp_driver #(
    parameter int RAMP_DIV  = 4,
    parameter int FAULT_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ignition,
    input  logic       headlights,
    input  logic [7:0] dim_level,
    input  logic       lamp_fault,
    input  logic       fault_clr,
    output logic       lamp_pwm,
    output logic [7:0] lamp_level,
    output logic       ramp_busy,
    output logic       fault,
    output logic [2:0] drv_state
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int FW = $clog2(FAULT_CNT + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(RAMP_DIV - 1);
    localparam logic [FW-1:0] FC_MAX = FW'(FAULT_CNT);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_ON        = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      target;
    logic [7:0]      cur;
    logic [7:0]      shadow;
    logic [7:0]      pwm_cnt;
    logic [PW-1:0]   prescaler;
    logic [FW-1:0]   fcnt;
    logic            tick;
    logic            fault_hit;

    assign target    = (ignition && headlights) ? dim_level : 8'd0;
    assign tick      = (prescaler == PRE_MAX);
    assign fault_hit = (fcnt == FC_MAX);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a latched fault count overrides everything.
    always_comb begin
        next_state = state;
        unique case (state)
            S_OFF: begin
                if (target != 8'd0) next_state = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (cur == target)     next_state = S_ON;
                else if (target < cur) next_state = S_RAMP_DOWN;
            end
            S_ON: begin
                if (target > cur)      next_state = S_RAMP_UP;
                else if (target < cur) next_state = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (cur == target) begin
                    next_state = (target == 8'd0) ? S_OFF : S_ON;
                end else if (target > cur) begin
                    next_state = S_RAMP_UP;
                end
            end
            S_FAULT: begin
                if (fault_clr) next_state = S_OFF;
            end
            default: next_state = S_OFF;
        endcase
        if (state != S_FAULT && fault_hit) next_state = S_FAULT;
    end

    // Free-running ramp prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Ramped brightness; zeroed on fault entry, guarded at the rails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= 8'd0;
        end else if (next_state == S_FAULT) begin
            cur <= 8'd0;
        end else if (tick && state == S_RAMP_UP && cur != 8'hFF) begin
            cur <= cur + 8'd1;
        end else if (tick && state == S_RAMP_DOWN && cur != 8'd0) begin
            cur <= cur - 8'd1;
        end
    end

    // PWM period counter, shadowed duty and registered gate drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= 8'd0;
            shadow   <= 8'd0;
            lamp_pwm <= 1'b0;
        end else begin
            if (pwm_cnt == 8'd254) begin
                pwm_cnt <= 8'd0;
                shadow  <= cur;
            end else begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            lamp_pwm <= (pwm_cnt < shadow) && (state != S_FAULT);
        end
    end

    // Consecutive driven-fault counter; undriven cycles are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (state == S_FAULT && fault_clr) begin
            fcnt <= '0;
        end else if (lamp_pwm) begin
            if (!lamp_fault) begin
                fcnt <= '0;
            end else if (!fault_hit) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign lamp_level = cur;
    assign ramp_busy  = (state == S_RAMP_UP) || (state == S_RAMP_DOWN);
    assign fault      = (state == S_FAULT);
    assign drv_state  = state;

endmodule

// File: doc/headlight_lamp_driver.md
Name: headlight_lamp_driver

Overview:
- Lamp-side consumer of the headlight controller's `headlights`/`dim_level` outputs.
- Turns the requested brightness into a soft-ramped, glitch-free PWM drive for the headlamp power stage.
- Latches an open/short lamp fault reported by the current-sense comparator and blanks the lamp until the fault is cleared.
- Sits between the headlight controller and the lamp FET gate driver.

Parameters:
- RAMP_DIV, 4, clocks per brightness ramp step (≥2); one step = ±1 level.
- FAULT_CNT, 3, consecutive PWM-on cycles with lamp_fault=1 needed to latch a fault (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- ignition  in  1  ignition on
- headlights  in  1  headlight request from the controller
- dim_level  in  8  requested brightness, 0..255
- lamp_fault  in  1  current-sense fault flag; valid only while the lamp is driven
- fault_clr  in  1  single-cycle pulse that clears a latched fault
- lamp_pwm  out  1  registered PWM gate drive
- lamp_level  out  8  current ramped brightness (cur)
- ramp_busy  out  1  high in RAMP_UP or RAMP_DOWN
- fault  out  1  latched fault indicator
- drv_state  out  3  FSM state: OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3, FAULT=4

Behaviour:
- Reset values (rst_n=0, async): state OFF, cur=0, shadow=0, pwm_cnt=0, prescaler=0, fault counter=0, lamp_pwm=0, fault=0, ramp_busy=0.
- Target: target = (ignition & headlights) ? dim_level : 0. Inputs are synchronous to clk and sampled every cycle.
- Prescaler: counts 0..RAMP_DIV-1 and wraps. tick = (prescaler == RAMP_DIV-1). Free-running in every state.
- Ramp: on tick, cur increments by 1 in RAMP_UP and decrements by 1 in RAMP_DOWN. Otherwise cur holds. No overflow or underflow is possible, because transitions leave the ramp states at equality.
- FSM transitions (registered, evaluated every cycle from the current cur and target):
  - OFF: target>0 → RAMP_UP.
  - RAMP_UP: cur==target → ON; target<cur → RAMP_DOWN.
  - ON: target>cur → RAMP_UP; target<cur → RAMP_DOWN.
  - RAMP_DOWN: cur==target → OFF if target==0, else ON; target>cur → RAMP_UP.
  - Any non-FAULT state: fault counter reaches FAULT_CNT → FAULT. This has priority over all other transitions.
  - FAULT: cur forced to 0 in the entry cycle; lamp_pwm=0; fault=1. fault_clr=1 → OFF with fault=0. The fault counter is cleared and the lamp then re-ramps from 0 if target>0.
- State hand-off at equality: the state reaches ON/OFF the cycle after cur==target.
- Target changes during a ramp reverse direction without waiting for a tick.
- PWM:
  - 8-bit pwm_cnt counts 0..254 and wraps, giving a period of 255 clocks.
  - shadow loads cur when pwm_cnt==254, so each duty value takes effect from the next period start.
  - lamp_pwm (registered) = (pwm_cnt < shadow) & (state != FAULT).
  - shadow=0 → constant low; shadow=255 → constant high. Duty = shadow/255.
- Fault counter:
  - Increments on each cycle with lamp_pwm=1 and lamp_fault=1.
  - Clears on any cycle with lamp_pwm=1 and lamp_fault=0.
  - Holds while lamp_pwm=0, so an undriven lamp is ignored.
  - Saturates at FAULT_CNT.
- Simultaneous events:
  - fault_clr while not in FAULT has no effect.
  - Fault condition and target change in the same cycle → FAULT wins.
  - Ignition drop behaves as target=0: a normal ramp down, not an instant cut.
- Reset mid-ramp immediately returns all outputs to reset values.
- Outputs: lamp_level=cur; ramp_busy is decoded from state.

Test Plan (RAMP_DIV=4, FAULT_CNT=3):
- Ignition=0, headlights=1, dim_level=200 for 300 cycles → state OFF, lamp_level=0, lamp_pwm never 1.
- Ignition=1, headlights=1, dim_level=8 from OFF:
  - lamp_level steps 1..8, one step every 4 clocks, with ramp_busy=1 during the ramp.
  - ON is reached 1 cycle after lamp_level=8.
  - Steady-state lamp_pwm is high for exactly 8 of every 255 clocks.
- At ON level 8, change dim_level to 3 → RAMP_DOWN, lamp_level reaches 3 after 5 ticks, then ON. Next, drop ignition → ramp to 0, then OFF.
- Mid-ramp reversal: dim_level=20, and when lamp_level=10 change to 5 → state goes RAMP_DOWN the next cycle, lamp_level never exceeds 10 or 11, and it settles at 5.
- dim_level=255 at ON → lamp_pwm constant 1. Hold lamp_fault=1 for 3 on-cycles → FAULT, fault=1, lamp_pwm=0 next cycle, lamp_level=0. A 2-cycle lamp_fault glitch must not latch a fault.
- In FAULT, pulse fault_clr with target=255 → OFF, fault=0, then RAMP_UP from 0. Assert rst_n=0 mid-ramp → all outputs immediately 0 and state OFF.
